// File: rtl/nonoverlap_pkg.sv
// Shared state encoding and gate-pair helper for the multi-channel dead-time generator.
package nonoverlap_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_OFF   = 2'd0;
  localparam state_t ST_DEAD  = 2'd1;
  localparam state_t ST_DRIVE = 2'd2;

  // Returns {high, low}. A conflicting (both-high) or idle command yields both low.
  function automatic logic [1:0] gate_pair(input logic hi, input logic lo);
    return {hi & ~lo, lo & ~hi};
  endfunction

endpackage

// File: rtl/nonoverlap_ch.sv
// One half-bridge channel: input synchroniser, change detect, dead-time FSM,
// registered gate outputs and sticky shoot-through fault flag.
module nonoverlap_ch
  import nonoverlap_pkg::*;
#(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [DT_W-1:0] dead_time,
  input  logic            fault_clr,
  input  logic            hi_raw,
  input  logic            lo_raw,
  output logic            hi_drv,
  output logic            lo_drv,
  output logic            fault
);

  logic            hi_meta, lo_meta;
  logic            s_hi, s_lo;
  logic            prev_hi, prev_lo;
  logic            chg;
  state_t          state, state_nxt;
  logic [DT_W-1:0] cnt, cnt_nxt;
  logic [1:0]      drive_nxt;

  // Two-flop synchronisers plus one history flop per command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_meta <= 1'b0;
      lo_meta <= 1'b0;
      s_hi    <= 1'b0;
      s_lo    <= 1'b0;
      prev_hi <= 1'b0;
      prev_lo <= 1'b0;
    end else begin
      hi_meta <= hi_raw;
      lo_meta <= lo_raw;
      s_hi    <= hi_meta;
      s_lo    <= lo_meta;
      prev_hi <= s_hi;
      prev_lo <= s_lo;
    end
  end

  assign chg = (s_hi != prev_hi) | (s_lo != prev_lo);

  // Next-state and counter logic; en dominates any command change.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_OFF: begin
        if (en) begin
          state_nxt = ST_DEAD;
          cnt_nxt   = dead_time;
        end else begin
          state_nxt = ST_OFF;
          cnt_nxt   = {DT_W{1'b0}};
        end
      end
      ST_DEAD: begin
        if (!en) begin
          state_nxt = ST_OFF;
          cnt_nxt   = {DT_W{1'b0}};
        end else if (chg) begin
          state_nxt = ST_DEAD;
          cnt_nxt   = dead_time;
        end else if (cnt == {DT_W{1'b0}}) begin
          state_nxt = ST_DRIVE;
        end else begin
          cnt_nxt = cnt - DT_W'(1);
        end
      end
      ST_DRIVE: begin
        if (!en) begin
          state_nxt = ST_OFF;
          cnt_nxt   = {DT_W{1'b0}};
        end else if (chg) begin
          state_nxt = ST_DEAD;
          cnt_nxt   = dead_time;
        end else begin
          state_nxt = ST_DRIVE;
        end
      end
      default: begin
        state_nxt = ST_OFF;
        cnt_nxt   = {DT_W{1'b0}};
      end
    endcase
  end

  // Gate outputs are derived from the next state so they register in the same edge.
  always_comb begin
    if (state_nxt == ST_DRIVE) begin
      drive_nxt = gate_pair(s_hi, s_lo);
    end else begin
      drive_nxt = 2'b00;
    end
  end

  // State, counter, gate and sticky fault registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_OFF;
      cnt    <= {DT_W{1'b0}};
      hi_drv <= 1'b0;
      lo_drv <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      hi_drv <= drive_nxt[1];
      lo_drv <= drive_nxt[0];
      fault  <= (s_hi & s_lo) | (fault & ~fault_clr);
    end
  end

endmodule

// File: rtl/nonoverlap_multi.sv
// Multi-channel dead-time generator: NUM_CH independent channels sharing
// enable, dead-time setting and fault clear.
module nonoverlap_multi
  import nonoverlap_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DT_W-1:0]   dead_time,
  input  logic              fault_clr,
  input  logic [NUM_CH-1:0] highIn,
  input  logic [NUM_CH-1:0] lowIn,
  output logic [NUM_CH-1:0] highOut,
  output logic [NUM_CH-1:0] lowOut,
  output logic [NUM_CH-1:0] fault
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    nonoverlap_ch #(
      .DT_W(DT_W)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .dead_time (dead_time),
      .fault_clr (fault_clr),
      .hi_raw    (highIn[i]),
      .lo_raw    (lowIn[i]),
      .hi_drv    (highOut[i]),
      .lo_drv    (lowOut[i]),
      .fault     (fault[i])
    );
  end

endmodule

// File: tb/tb_nonoverlap_multi.sv
// Scoreboard bench: an event-timing reference model predicts every cycle's
// outputs, a separate monitor compares them on the falling edge.
module tb_nonoverlap_multi;

  localparam int NUM_CH = 3;
  localparam int DT_W   = 8;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic [DT_W-1:0]   dead_time;
  logic              fault_clr;
  logic [NUM_CH-1:0] highIn, lowIn;
  logic [NUM_CH-1:0] highOut, lowOut, fault;

  typedef struct packed {
    logic [NUM_CH-1:0] hi;
    logic [NUM_CH-1:0] lo;
    logic [NUM_CH-1:0] flt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  nonoverlap_multi #(
    .NUM_CH(NUM_CH),
    .DT_W  (DT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .dead_time (dead_time),
    .fault_clr (fault_clr),
    .highIn    (highIn),
    .lowIn     (lowIn),
    .highOut   (highOut),
    .lowOut    (lowOut),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, want);
    end
  endtask

  // Reference model: a channel drives only when en has been held and no
  // synchronised command change has occurred for more than D edges since the
  // latest interval start (en rise or change). Commands seen at edge u are the
  // raw values sampled two edges earlier.
  initial begin : model
    logic [NUM_CH-1:0] hist_hi[$];
    logic [NUM_CH-1:0] hist_lo[$];
    logic [NUM_CH-1:0] m_fault, cmd_hi, cmd_lo, old_hi, old_lo, chg;
    logic              en_was;
    int unsigned       start[NUM_CH];
    int unsigned       dsel[NUM_CH];
    int unsigned       u;
    int                n;
    exp_t              e;
    u = 0;
    en_was = 1'b0;
    m_fault = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      start[c] = 0;
      dsel[c]  = 0;
    end
    forever begin
      @(posedge clk);
      u++;
      e = '0;
      if (!rst_n) begin
        hist_hi = {NUM_CH'(0), NUM_CH'(0), NUM_CH'(0)};
        hist_lo = {NUM_CH'(0), NUM_CH'(0), NUM_CH'(0)};
        m_fault = '0;
        en_was  = 1'b0;
      end else begin
        hist_hi.push_back(highIn);
        hist_lo.push_back(lowIn);
        if (hist_hi.size() > 6) begin
          void'(hist_hi.pop_front());
          void'(hist_lo.pop_front());
        end
        n      = hist_hi.size();
        cmd_hi = hist_hi[n-3];
        cmd_lo = hist_lo[n-3];
        old_hi = hist_hi[n-4];
        old_lo = hist_lo[n-4];
        chg    = (cmd_hi ^ old_hi) | (cmd_lo ^ old_lo);
        for (int c = 0; c < NUM_CH; c++) begin
          if (en) begin
            if (!en_was || chg[c]) begin
              start[c] = u;
              dsel[c]  = dead_time;
            end
            if (u >= start[c] + dsel[c] + 1) begin
              e.hi[c] = cmd_hi[c] & ~cmd_lo[c];
              e.lo[c] = cmd_lo[c] & ~cmd_hi[c];
            end
          end
        end
        m_fault = (m_fault & ~{NUM_CH{fault_clr}}) | (cmd_hi & cmd_lo);
        e.flt   = m_fault;
        en_was  = en;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: pops one expectation per cycle and checks mutual exclusion.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("highOut", highOut, e.hi);
        chk("lowOut", lowOut, e.lo);
        chk("fault", fault, e.flt);
      end
      chk("no_overlap", highOut & lowOut, {NUM_CH{1'b0}});
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog t=%0t actual=running expected=finished", $time);
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_drop_hi", highOut, {NUM_CH{1'b0}});
    chk("rst_drop_lo", lowOut, {NUM_CH{1'b0}});
    chk("rst_drop_fault", fault, {NUM_CH{1'b0}});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin : stim
    rst_n = 1'b0; en = 1'b0; dead_time = 8'd0; fault_clr = 1'b0;
    highIn = 3'b000; lowIn = 3'b000;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    // Basic switch-on of channel 0 with D=5.
    en = 1'b1; dead_time = 8'd5;
    tick(3);
    highIn[0] = 1'b1;
    tick(15);
    // Complementary switch on channel 1 with D=0.
    dead_time = 8'd0;
    highIn[1] = 1'b1;
    tick(6);
    highIn[1] = 1'b0; lowIn[1] = 1'b1;
    tick(8);
    // Glitch restart on channel 2 with D=10.
    dead_time = 8'd10;
    highIn[2] = 1'b1;
    tick(3);
    highIn[2] = 1'b0;
    tick(4);
    highIn[2] = 1'b1;
    tick(20);
    // Shoot-through fault on channel 0, clear, and clear racing a set.
    lowIn[0] = 1'b1;
    tick(6);
    highIn[0] = 1'b0; lowIn[0] = 1'b0;
    tick(5);
    fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
    tick(3);
    highIn[0] = 1'b1; lowIn[0] = 1'b1;
    tick(4);
    fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
    tick(3);
    lowIn[0] = 1'b0;
    tick(3);
    fault_clr = 1'b1; tick(1); fault_clr = 1'b0;
    tick(12);
    // en dropped while driving, then re-raised with D=3.
    en = 1'b0;
    tick(3);
    dead_time = 8'd3; en = 1'b1;
    tick(10);
    // dead_time raised mid-interval only affects the next load.
    highIn[1] = 1'b1; lowIn[1] = 1'b0;
    tick(3);
    dead_time = 8'd20;
    tick(8);
    highIn[1] = 1'b0; lowIn[1] = 1'b1;
    tick(30);
    // Maximum dead interval.
    dead_time = 8'd255;
    highIn[2] = 1'b0;
    tick(265);
    // Async reset mid-interval.
    dead_time = 8'd4;
    highIn[0] = 1'b0;
    tick(4);
    async_reset();
    tick(12);
    // Randomised phase.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(11, 0) == 0) begin
        highIn = NUM_CH'($urandom);
        lowIn  = NUM_CH'($urandom);
        if ($urandom_range(3, 0) != 0) lowIn = lowIn & ~highIn;
      end
      if ($urandom_range(39, 0) == 0) en = ~en;
      if ($urandom_range(15, 0) == 0) begin
        if ($urandom_range(19, 0) == 0) dead_time = DT_W'($urandom);
        else dead_time = DT_W'($urandom_range(6, 0));
      end
      fault_clr = ($urandom_range(15, 0) == 0);
      if ($urandom_range(249, 0) == 0) async_reset();
      else tick(1);
    end
    fault_clr = 1'b0;
    tick(2);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
